key_event_arbiter: RTL

Turns the four one-cycle key-press pulses from the falling-edge detector into an ordered stream of key events for the game logic. Each key gets a lockout window that suppresses bounce, a one-deep pending slot, and round-robin arbitration onto a single valid/ready event port. It sits between the key edge-detection stage and the game FSM.

---
 rtl/key_pkg.sv | 29 ++
 rtl/key_lock_timer.sv | 29 ++
 rtl/key_event_arbiter.sv | 77 +++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key event path: key count, key index type,
// arbiter reset pointer and the round-robin pick helper.
package key_pkg;

    localparam int NUM_KEYS = 4;

    typedef logic [1:0] key_idx_t;

    // Pointer reset to the last key so key 0 has first priority after reset.
    localparam key_idx_t RR_PTR_RST = 2'd3;

    // First requesting key found scanning from ptr+1 upward, wrapping mod NUM_KEYS.
    function automatic key_idx_t rr_pick(input logic [NUM_KEYS-1:0] req, input key_idx_t ptr);
        key_idx_t idx;
        key_idx_t win;
        logic     found;
        win   = ptr;
        found = 1'b0;
        for (int i = 1; i <= NUM_KEYS; i++) begin
            idx = ptr + key_idx_t'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/key_lock_timer.sv
// Per-key lockout counter: start loads LOCK_CYCLES, then it counts down to zero.
// The key is locked for the LOCK_CYCLES cycles following the start pulse.
module key_lock_timer #(
    parameter int LOCK_CYCLES = 1_000_000,
    parameter int CNT_W       = $clog2(LOCK_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic locked
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOCK_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign locked = (cnt != '0);

endmodule

// File: rtl/key_event_arbiter.sv
// Debounced key press pulses -> one-deep pending slot per key -> round-robin
// arbitration onto a registered valid/ready event port.
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int LOCK_CYCLES = 1_000_000,
    parameter int CNT_W       = $clog2(LOCK_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] press,
    output logic       evt_valid,
    output logic [1:0] evt_key,
    input  logic       evt_ready,
    output logic [3:0] pending,
    output logic [3:0] ovf,
    input  logic       ovf_clr
);

    // Handshake: an event transfers on a cycle with evt_valid && evt_ready; while
    // evt_valid is high and evt_ready low, evt_valid and evt_key hold stable.

    logic [3:0] locked;
    logic [3:0] accept;
    logic [3:0] grant;
    logic [3:0] overflow;
    logic       load;
    key_idx_t   winner;
    key_idx_t   rr_ptr;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_lock
        key_lock_timer #(
            .LOCK_CYCLES(LOCK_CYCLES),
            .CNT_W      (CNT_W)
        ) u_lock (
            .clk   (clk),
            .rst   (rst),
            .start (accept[k]),
            .locked(locked[k])
        );
    end

    always_comb begin
        load   = !evt_valid || evt_ready;
        winner = rr_pick(pending, rr_ptr);
        accept = press & ~locked;
        grant  = '0;
        if (load && (pending != '0)) begin
            grant[winner] = 1'b1;
        end
        // A slot being granted this cycle is free to take the new press.
        overflow = accept & pending & ~grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            ovf       <= '0;
            evt_valid <= 1'b0;
            evt_key   <= '0;
            rr_ptr    <= RR_PTR_RST;
        end else begin
            pending <= (pending & ~grant) | accept;
            ovf     <= (ovf_clr ? 4'b0000 : ovf) | overflow;
            if (load) begin
                if (pending != '0) begin
                    evt_valid <= 1'b1;
                    evt_key   <= winner;
                    rr_ptr    <= winner;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

endmodule
